alarm_sequencer: RTL and testbench

- Sequences the alarm/sound path of the clock: decides when the alarm rings, snoozes, auto-silences and re-arms.
- Takes the registered alarm-match flag from the comparator module and timing ticks from the clock datapath.
- Drives Sound and status flags to the display and buzzer.
- Replaces ad-hoc ring logic with a timed state machine: bounded snooze count, ring timeout, same-minute retrigger lockout.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/snooze_timer.sv | 44 ++++
 rtl/alarm_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, counter width,
// default timing parameters and a saturating increment helper.
package alarm_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RING   = 2'b01,
        ST_SNOOZE = 2'b10,
        ST_HOLD   = 2'b11
    } alarmState_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [CNT_W-1:0] DEF_SNOOZE_MIN       = CNT_W'(9);
    localparam logic [CNT_W-1:0] DEF_RING_TIMEOUT_MIN = CNT_W'(10);
    localparam logic [CNT_W-1:0] DEF_MAX_SNOOZE       = CNT_W'(3);

    // Counters stick at all-ones instead of wrapping back to zero
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/snooze_timer.sv
// Loadable 4-bit down-counter holding the remaining snooze minutes.
// expire_o flags the minute tick that takes the count from 1 to 0, so the
// sequencer can leave SNOOZE on the same edge the count reaches zero.
module snooze_timer
    import alarm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstN_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadVal_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear beats load beats decrement; decrement never goes below zero
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = dec_i && (count_q == CNT_ONE);
    assign count_o  = count_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/auto-silence sequencer. Buttons are rising-edge detected
// into one-cycle event registers, the FSM reacts to those events on the next
// edge, and every output is taken straight from a flop.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter logic [CNT_W-1:0] SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter logic [CNT_W-1:0] RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
    parameter logic [CNT_W-1:0] MAX_SNOOZE       = DEF_MAX_SNOOZE
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             AA,
    input  logic             AlarmEn,
    input  logic             MinTick,
    input  logic             BeepTick,
    input  logic             Snooze,
    input  logic             Stop,
    input  logic             Mute,
    output logic             Sound,
    output logic             Ringing,
    output logic             Snoozing,
    output logic [CNT_W-1:0] SnzLeft,
    output logic [CNT_W-1:0] SnzCount
);

    alarmState_e      state_q;
    alarmState_e      state_d;

    logic             snzPrev_q;
    logic             stopPrev_q;
    logic             snzEvt_q;
    logic             stopEvt_q;

    logic [CNT_W-1:0] ringMin_q;
    logic [CNT_W-1:0] ringMin_d;
    logic             phase_q;
    logic             phase_d;
    logic [CNT_W-1:0] snzCount_q;
    logic [CNT_W-1:0] snzCount_d;
    logic             sound_q;
    logic             sound_d;
    logic             ringing_q;
    logic             ringing_d;
    logic             snoozing_q;
    logic             snoozing_d;

    logic             tmrLoad;
    logic             tmrClear;
    logic             tmrDec;
    logic             tmrExpire;
    logic [CNT_W-1:0] tmrCount;

    logic             timeoutHit;
    logic             snoozeAllowed;

    assign timeoutHit    = MinTick && (ringMin_q == (RING_TIMEOUT_MIN - CNT_ONE));
    assign snoozeAllowed = (snzCount_q < MAX_SNOOZE);

    // Button edge detectors; reset loads the live level so a held button never fires
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            snzPrev_q  <= Snooze;
            stopPrev_q <= Stop;
            snzEvt_q   <= 1'b0;
            stopEvt_q  <= 1'b0;
        end else begin
            snzPrev_q  <= Snooze;
            stopPrev_q <= Stop;
            snzEvt_q   <= Snooze & ~snzPrev_q;
            stopEvt_q  <= Stop & ~stopPrev_q;
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; disarming the alarm overrides every other transition
    always_comb begin
        state_d = state_q;
        if (!AlarmEn) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (AA) state_d = ST_RING;
                end
                ST_RING: begin
                    if (stopEvt_q || timeoutHit) begin
                        state_d = ST_HOLD;
                    end else if (snzEvt_q) begin
                        state_d = snoozeAllowed ? ST_SNOOZE : ST_HOLD;
                    end
                end
                ST_SNOOZE: begin
                    if (stopEvt_q) begin
                        state_d = ST_HOLD;
                    end else if (tmrExpire) begin
                        state_d = ST_RING;
                    end
                end
                ST_HOLD: begin
                    if (!AA) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counter, beep-phase and output next values derived from the transition taken
    always_comb begin
        ringMin_d  = ringMin_q;
        phase_d    = phase_q;
        snzCount_d = snzCount_q;
        tmrDec     = MinTick && (state_q == ST_SNOOZE);
        tmrClear   = (state_d != ST_SNOOZE);
        tmrLoad    = (state_q != ST_SNOOZE) && (state_d == ST_SNOOZE);
        if (!AlarmEn) begin
            ringMin_d  = '0;
            phase_d    = 1'b0;
            snzCount_d = '0;
        end else begin
            if (state_d == ST_RING) begin
                if (state_q != ST_RING) begin
                    ringMin_d = '0;
                    phase_d   = 1'b1;
                    if (state_q == ST_IDLE) snzCount_d = '0;
                end else begin
                    if (BeepTick) phase_d = ~phase_q;
                    if (MinTick) ringMin_d = satInc(ringMin_q);
                end
            end else begin
                phase_d = 1'b0;
            end
            if (tmrLoad) snzCount_d = satInc(snzCount_q);
            if ((state_q == ST_HOLD) && (state_d == ST_IDLE)) snzCount_d = '0;
        end
        ringing_d  = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
        sound_d    = (state_d == ST_RING) && phase_d && !Mute;
    end

    // Registered counters and outputs
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            ringMin_q  <= '0;
            phase_q    <= 1'b0;
            snzCount_q <= '0;
            sound_q    <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            ringMin_q  <= ringMin_d;
            phase_q    <= phase_d;
            snzCount_q <= snzCount_d;
            sound_q    <= sound_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
        end
    end

    snooze_timer uSnoozeTimer (
        .clk_i     (Clk),
        .rstN_i    (Clr),
        .clear_i   (tmrClear),
        .load_i    (tmrLoad),
        .loadVal_i (SNOOZE_MIN),
        .dec_i     (tmrDec),
        .count_o   (tmrCount),
        .expire_o  (tmrExpire)
    );

    assign Sound    = sound_q;
    assign Ringing  = ringing_q;
    assign Snoozing = snoozing_q;
    assign SnzLeft  = tmrCount;
    assign SnzCount = snzCount_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed walk through ring/snooze/hold scenarios
// followed by randomized inputs, all compared every cycle against a
// behavioural model of the alarm rules.
module tb_alarm_sequencer;

    localparam int SNZ_MIN = 9;
    localparam int TIMEOUT = 10;
    localparam int MAX_SNZ = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SNOOZE = 2;
    localparam int M_HOLD   = 3;

    logic       Clk = 1'b0;
    logic       Clr, AA, AlarmEn, MinTick, BeepTick, Snooze, Stop, Mute;
    logic       Sound, Ringing, Snoozing;
    logic [3:0] SnzLeft, SnzCount;

    int errors = 0;
    int checks = 0;

    int mMode, mRingMin, mLeft, mUsed;
    bit mPhase, mSound, mSnzPend, mStopPend, mPrevSnz, mPrevStop;

    alarm_sequencer dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .AA       (AA),
        .AlarmEn  (AlarmEn),
        .MinTick  (MinTick),
        .BeepTick (BeepTick),
        .Snooze   (Snooze),
        .Stop     (Stop),
        .Mute     (Mute),
        .Sound    (Sound),
        .Ringing  (Ringing),
        .Snoozing (Snoozing),
        .SnzLeft  (SnzLeft),
        .SnzCount (SnzCount)
    );

    always #5 Clk = ~Clk;

    // Reference model: advances one clock edge using the input levels present at that edge
    task automatic modelStep();
        bit newSnz, newStop;
        if (!Clr) begin
            mMode = M_IDLE; mRingMin = 0; mLeft = 0; mUsed = 0;
            mPhase = 0; mSound = 0; mSnzPend = 0; mStopPend = 0;
            mPrevSnz = Snooze; mPrevStop = Stop;
        end else begin
            newSnz    = Snooze && !mPrevSnz;
            newStop   = Stop && !mPrevStop;
            mPrevSnz  = Snooze;
            mPrevStop = Stop;
            if (!AlarmEn) begin
                mMode = M_IDLE; mRingMin = 0; mLeft = 0; mUsed = 0; mPhase = 0;
            end else begin
                case (mMode)
                    M_IDLE: if (AA) begin
                        mMode = M_RING; mRingMin = 0; mUsed = 0; mPhase = 1;
                    end
                    M_RING: begin
                        if (mStopPend || (MinTick && mRingMin == TIMEOUT - 1)) begin
                            mMode = M_HOLD;
                        end else if (mSnzPend) begin
                            if (mUsed < MAX_SNZ) begin
                                mMode = M_SNOOZE; mLeft = SNZ_MIN; mUsed++;
                            end else begin
                                mMode = M_HOLD;
                            end
                        end else begin
                            if (BeepTick) mPhase = !mPhase;
                            if (MinTick && mRingMin < 15) mRingMin++;
                        end
                    end
                    M_SNOOZE: begin
                        if (mStopPend) begin
                            mMode = M_HOLD; mLeft = 0;
                        end else if (MinTick) begin
                            mLeft--;
                            if (mLeft == 0) begin
                                mMode = M_RING; mRingMin = 0; mPhase = 1;
                            end
                        end
                    end
                    default: if (!AA) begin
                        mMode = M_IDLE; mUsed = 0; mLeft = 0;
                    end
                endcase
                if (mMode != M_RING) mPhase = 0;
            end
            mSound    = (mMode == M_RING) && mPhase && !Mute;
            mSnzPend  = newSnz;
            mStopPend = newStop;
        end
    endtask

    task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("Ringing",  {3'b000, Ringing},  (mMode == M_RING)   ? 4'd1 : 4'd0);
        checkOne("Snoozing", {3'b000, Snoozing}, (mMode == M_SNOOZE) ? 4'd1 : 4'd0);
        checkOne("Sound",    {3'b000, Sound},    mSound ? 4'd1 : 4'd0);
        checkOne("SnzLeft",  SnzLeft,  4'(mLeft));
        checkOne("SnzCount", SnzCount, 4'(mUsed));
    endtask

    // Hold the current input levels for n edges, checking after each
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            modelStep();
            #1;
            checkOutput();
        end
    endtask

    task automatic pressSnooze();
        Snooze = 1; applyStimulus(1);
        Snooze = 0; applyStimulus(2);
    endtask

    task automatic minTicks(input int n);
        for (int i = 0; i < n; i++) begin
            MinTick = 1; applyStimulus(1);
            MinTick = 0; applyStimulus(1);
        end
    endtask

    initial begin
        Clr = 0; AA = 0; AlarmEn = 0; MinTick = 0; BeepTick = 0;
        Snooze = 1; Stop = 0; Mute = 0;

        $display("[TB] reset with Snooze held");
        applyStimulus(2);
        Clr = 1;
        applyStimulus(3);
        Snooze = 0;
        applyStimulus(2);

        $display("[TB] ring, beep and mute");
        AlarmEn = 1; applyStimulus(1);
        AA = 1; applyStimulus(2);
        for (int i = 0; i < 4; i++) begin
            BeepTick = 1; applyStimulus(1);
            BeepTick = 0; applyStimulus(1);
        end
        BeepTick = 1; applyStimulus(1);
        BeepTick = 0;
        Mute = 1; applyStimulus(2);
        Mute = 0; applyStimulus(1);

        $display("[TB] snooze cycles up to the limit");
        pressSnooze();
        minTicks(SNZ_MIN);
        pressSnooze();
        minTicks(SNZ_MIN);
        pressSnooze();
        minTicks(SNZ_MIN);
        pressSnooze();
        AA = 0; applyStimulus(2);

        $display("[TB] ring timeout and same-minute lockout");
        AA = 1; applyStimulus(2);
        minTicks(TIMEOUT);
        applyStimulus(5);
        AA = 0; applyStimulus(2);

        $display("[TB] simultaneous Stop and Snooze");
        AA = 1; applyStimulus(2);
        Stop = 1; Snooze = 1; applyStimulus(1);
        Stop = 0; Snooze = 0; applyStimulus(2);
        AA = 0; applyStimulus(2);

        $display("[TB] disarm during snooze");
        AA = 1; applyStimulus(2);
        pressSnooze();
        AA = 0; minTicks(2);
        AlarmEn = 0; applyStimulus(2);
        AlarmEn = 1; applyStimulus(1);

        $display("[TB] randomized stimulus");
        for (int c = 0; c < 4000; c++) begin
            Clr      = ($urandom_range(0, 299) != 0);
            AlarmEn  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) AA = ~AA;
            MinTick  = ($urandom_range(0, 3) == 0);
            BeepTick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0)  Snooze = ~Snooze;
            if ($urandom_range(0, 14) == 0) Stop = ~Stop;
            if ($urandom_range(0, 9) == 0)  Mute = ~Mute;
            applyStimulus(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
